// File: rtl/spi_slave_gen.sv
// SPI slave front-end: deserialises {cmd, data} frames from MOSI and serialises RAM read data on MISO.
// rx_valid pulses one cycle after the last frame bit; SS_n release mid-frame aborts with a frame_err pulse.
module spi_slave_gen #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CW      = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, RD_ADDR, RD_DATA, RD_WAIT, RD_TX, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]    tx_q, tx_d;
  logic                 miso_q, miso_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 pend_q, pend_d;

  logic [FRAME_W-1:0]   word_in;
  logic                 tx_first, tx_next;
  logic [DATA_W-1:0]    tx_load, tx_shift;

  assign word_in  = MSB_FIRST ? {shift_q[FRAME_W-2:0], MOSI} : {MOSI, shift_q[FRAME_W-1:1]};
  assign tx_first = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
  assign tx_load  = MSB_FIRST ? {tx_data[DATA_W-2:0], 1'b0} : {1'b0, tx_data[DATA_W-1:1]};
  assign tx_next  = MSB_FIRST ? tx_q[DATA_W-1] : tx_q[0];
  assign tx_shift = MSB_FIRST ? {tx_q[DATA_W-2:0], 1'b0} : {1'b0, tx_q[DATA_W-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    pend_d      = pend_q;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        cnt_d   = '0;
        shift_d = '0;
        if (SS_n)        state_d = IDLE;
        else if (!MOSI)  state_d = WRITE;
        else if (pend_q) state_d = RD_DATA;
        else             state_d = RD_ADDR;
      end
      WRITE, RD_ADDR, RD_DATA: begin
        // The final bit is accepted even when SS_n rises on the same edge.
        if (cnt_q == CW'(FRAME_W - 1)) begin
          shift_d    = word_in;
          cnt_d      = CW'(FRAME_W);
          rx_data_d  = word_in;
          rx_valid_d = 1'b1;
          if (state_q == RD_ADDR) pend_d = 1'b1;
          if (SS_n)                    state_d = IDLE;
          else if (state_q == RD_DATA) state_d = RD_WAIT;
          else                         state_d = DONE;
        end else if (SS_n) begin
          state_d     = IDLE;
          miso_d      = 1'b0;
          frame_err_d = (cnt_q != '0);
        end else begin
          shift_d = word_in;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      RD_WAIT: begin
        if (SS_n) begin
          state_d     = IDLE;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else if (tx_valid) begin
          tx_d    = tx_load;
          miso_d  = tx_first;
          cnt_d   = CW'(1);
          state_d = RD_TX;
        end
      end
      RD_TX: begin
        // cnt_q counts bits already presented on MISO.
        if (SS_n) begin
          state_d     = IDLE;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else if (cnt_q == CW'(DATA_W)) begin
          miso_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = DONE;
        end else begin
          miso_d = tx_next;
          tx_d   = tx_shift;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (SS_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      pend_q      <= pend_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: default 8-bit MSB-first instance plus a 16-bit LSB-first instance.
module tb_spi_slave_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        SS_n, MOSI, tx_valid;
  logic [7:0]  tx_data;
  logic        MISO, rx_valid, busy, frame_err;
  logic [9:0]  rx_data;

  logic        ss2, mosi2, tx_valid2;
  logic [15:0] tx_data2;
  logic        miso2, rx_valid2, busy2, ferr2;
  logic [17:0] rx_data2;

  int checks = 0;
  int passes = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;

  spi_slave_gen #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .tx_data(tx_data), .tx_valid(tx_valid),
    .MISO(MISO), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
  );

  spi_slave_gen #(.DATA_W(16), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .SS_n(ss2), .MOSI(mosi2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .MISO(miso2), .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2), .frame_err(ferr2)
  );

  always @(posedge clk) begin
    if (rx_valid)  rxv_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic drive(input logic ss, input logic mosi);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
  endtask

  // Full frame; returns at the negedge after the last-bit edge.
  task automatic send_frame(input logic chk, input logic [9:0] w, input logic last_ss);
    drive(1'b0, 1'b0);
    drive(1'b0, chk);
    for (int i = 9; i >= 1; i--) drive(1'b0, w[i]);
    drive(last_ss, w[0]);
    @(negedge clk);
  endtask

  task automatic drive2(input logic ss, input logic mosi);
    @(negedge clk);
    ss2   = ss;
    mosi2 = mosi;
  endtask

  task automatic send_frame2(input logic chk, input logic [17:0] w);
    drive2(1'b0, 1'b0);
    drive2(1'b0, chk);
    for (int i = 0; i < 18; i++) drive2(1'b0, w[i]);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    ss2 = 1'b1; mosi2 = 1'b0; tx_valid2 = 1'b0; tx_data2 = 16'h0000;
    repeat (3) @(negedge clk);
    checks++; if (MISO !== 1'b0) $display("FAIL reset_miso got=%b exp=0", MISO); else passes++;
    checks++; if (rx_data !== 10'h000) $display("FAIL reset_rx_data got=%h exp=000", rx_data); else passes++;
    checks++; if ({rx_valid, busy, frame_err} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {rx_valid, busy, frame_err}); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_write();
    int base;
    base = rxv_cnt;
    idle();
    send_frame(1'b0, 10'h0A5, 1'b0);
    checks++; if (rx_valid !== 1'b1) $display("FAIL wr_rx_valid got=%b exp=1", rx_valid); else passes++;
    checks++; if (rx_data !== 10'h0A5) $display("FAIL wr_rx_data got=%h exp=0a5", rx_data); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL wr_busy_done got=%b exp=1", busy); else passes++;
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (rx_valid !== 1'b0) $display("FAIL wr_pulse_width got=%b exp=0", rx_valid); else passes++;
    checks++; if (MISO !== 1'b0) $display("FAIL wr_txv_ignored got=%b exp=0", MISO); else passes++;
    idle();
    checks++; if (busy !== 1'b0) $display("FAIL wr_busy_idle got=%b exp=0", busy); else passes++;
    checks++; if (rxv_cnt !== base + 1) $display("FAIL wr_pulse_count got=%0d exp=%0d", rxv_cnt, base + 1); else passes++;
  endtask

  task automatic test_read();
    logic [7:0] exp_byte;
    exp_byte = 8'hC6;
    idle();
    send_frame(1'b1, 10'h203, 1'b0);
    checks++; if (rx_data !== 10'h203) $display("FAIL rd_addr_data got=%h exp=203", rx_data); else passes++;
    idle();
    send_frame(1'b1, 10'h35A, 1'b0);
    checks++; if (rx_data !== 10'h35A) $display("FAIL rd_data_word got=%h exp=35a", rx_data); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL rd_wait_busy got=%b exp=1", busy); else passes++;
    @(negedge clk);
    checks++; if (MISO !== 1'b0) $display("FAIL rd_wait_miso got=%b exp=0", MISO); else passes++;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hC6;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      checks++; if (MISO !== exp_byte[7 - i])
        $display("FAIL rd_miso_bit%0d got=%b exp=%b", i, MISO, exp_byte[7 - i]); else passes++;
    end
    @(negedge clk);
    checks++; if (MISO !== 1'b0) $display("FAIL rd_miso_tail got=%b exp=0", MISO); else passes++;
    idle();
    // Pending address cleared: a read frame must route to RD_ADDR and ignore tx_valid.
    send_frame(1'b1, 10'h111, 1'b0);
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    checks++; if (MISO !== 1'b0) $display("FAIL rd_pend_cleared got=%b exp=0", MISO); else passes++;
    idle();
  endtask

  task automatic test_abort_write();
    int rb, fb;
    rb = rxv_cnt; fb = ferr_cnt;
    idle();
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, i[0]);
    drive(1'b1, 1'b0);
    @(negedge clk);
    checks++; if (frame_err !== 1'b1) $display("FAIL abw_frame_err got=%b exp=1", frame_err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL abw_busy got=%b exp=0", busy); else passes++;
    checks++; if (rx_data !== 10'h111) $display("FAIL abw_rx_data got=%h exp=111", rx_data); else passes++;
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) $display("FAIL abw_err_width got=%b exp=0", frame_err); else passes++;
    // SS_n release during the command bit is a silent return to IDLE.
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    @(negedge clk);
    checks++; if ({busy, frame_err} !== 2'b00) $display("FAIL abchk_flags got=%b exp=00", {busy, frame_err}); else passes++;
    idle();
    checks++; if (rxv_cnt !== rb) $display("FAIL abw_no_rx_valid got=%0d exp=%0d", rxv_cnt, rb); else passes++;
    checks++; if (ferr_cnt !== fb + 1) $display("FAIL abw_err_count got=%0d exp=%0d", ferr_cnt, fb + 1); else passes++;
  endtask

  task automatic test_abort_tx();
    send_frame(1'b1, 10'h3C3, 1'b0);
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (MISO !== 1'b1) $display("FAIL abt_bit0 got=%b exp=1", MISO); else passes++;
    @(negedge clk);
    checks++; if (MISO !== 1'b0) $display("FAIL abt_bit1 got=%b exp=0", MISO); else passes++;
    @(negedge clk);
    checks++; if (MISO !== 1'b1) $display("FAIL abt_bit2 got=%b exp=1", MISO); else passes++;
    SS_n = 1'b1;
    @(negedge clk);
    checks++; if (frame_err !== 1'b1) $display("FAIL abt_frame_err got=%b exp=1", frame_err); else passes++;
    checks++; if (MISO !== 1'b0) $display("FAIL abt_miso got=%b exp=0", MISO); else passes++;
    idle();
    send_frame(1'b1, 10'h3FF, 1'b0);
    tx_valid = 1'b1; tx_data = 8'h80;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (MISO !== 1'b1) $display("FAIL abt_pend_kept got=%b exp=1", MISO); else passes++;
    SS_n = 1'b1;
    @(negedge clk);
    checks++; if (frame_err !== 1'b1) $display("FAIL abt_second_err got=%b exp=1", frame_err); else passes++;
    idle();
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 10'h2CD, 1'b1);
    checks++; if (rx_valid !== 1'b1) $display("FAIL b2b_last_valid got=%b exp=1", rx_valid); else passes++;
    checks++; if (rx_data !== 10'h2CD) $display("FAIL b2b_last_data got=%h exp=2cd", rx_data); else passes++;
    checks++; if ({busy, frame_err} !== 2'b00) $display("FAIL b2b_last_idle got=%b exp=00", {busy, frame_err}); else passes++;
    send_frame(1'b0, 10'h155, 1'b0);
    checks++; if (rx_data !== 10'h155) $display("FAIL b2b_second got=%h exp=155", rx_data); else passes++;
    idle();
  endtask

  task automatic test_reset_mid();
    send_frame(1'b1, 10'h3AA, 1'b0);
    checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got=%b exp=1", busy); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (rx_data !== 10'h000) $display("FAIL rst_mid_rx_data got=%h exp=000", rx_data); else passes++;
    checks++; if ({MISO, rx_valid, busy, frame_err} !== 4'b0000)
      $display("FAIL rst_mid_flags got=%b exp=0000", {MISO, rx_valid, busy, frame_err}); else passes++;
    @(negedge clk);
    rst = 1'b0; SS_n = 1'b1;
    idle();
    send_frame(1'b1, 10'h0F0, 1'b0);
    checks++; if (rx_data !== 10'h0F0) $display("FAIL rst_post_data got=%h exp=0f0", rx_data); else passes++;
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    checks++; if (MISO !== 1'b0) $display("FAIL rst_pend_cleared got=%b exp=0", MISO); else passes++;
    idle();
  endtask

  task automatic test_lsb_first();
    drive2(1'b1, 1'b0);
    send_frame2(1'b0, 18'h1_2345);
    checks++; if (rx_valid2 !== 1'b1) $display("FAIL lsb_rx_valid got=%b exp=1", rx_valid2); else passes++;
    checks++; if (rx_data2 !== 18'h1_2345) $display("FAIL lsb_rx_data got=%h exp=12345", rx_data2); else passes++;
    drive2(1'b1, 1'b0);
    drive2(1'b1, 1'b0);
    send_frame2(1'b1, 18'h0_0007);
    drive2(1'b1, 1'b0);
    drive2(1'b1, 1'b0);
    send_frame2(1'b1, 18'h3_0000);
    tx_valid2 = 1'b1; tx_data2 = 16'h8001;
    @(negedge clk);
    tx_valid2 = 1'b0;
    checks++; if (miso2 !== 1'b1) $display("FAIL lsb_tx_bit0 got=%b exp=1", miso2); else passes++;
    @(negedge clk);
    checks++; if (miso2 !== 1'b0) $display("FAIL lsb_tx_bit1 got=%b exp=0", miso2); else passes++;
    ss2 = 1'b1;
    @(negedge clk);
    checks++; if (ferr2 !== 1'b1) $display("FAIL lsb_abort_err got=%b exp=1", ferr2); else passes++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort_write();
    test_abort_tx();
    test_back_to_back();
    test_reset_mid();
    test_lsb_first();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
